// File: rtl/sincos_nco_sched_if.sv
// Bus bundle for sincos_nco_sched: register-side writes, datapath issue/return, sample output.
// The master side is the control logic plus interpolator; the slave side is the scheduler.
interface sincos_nco_sched_if #(
   parameter int NCH = 4,
   parameter int PW  = 32,
   parameter int NBO = 23
);
   localparam int CW = $clog2(NCH);

   logic                  freq_we;
   logic [CW-1:0]         freq_ch;
   logic [PW-1:0]         freq_d;
   logic [NCH-1:0]        phase_clr;
   logic [NCH-1:0]        ch_en;
   logic [PW-1:0]         dp_phase;
   logic                  dp_valid;
   logic signed [NBO-1:0] dp_o;
   logic signed [NBO-1:0] o;
   logic [CW-1:0]         o_ch;
   logic                  o_valid;

   modport master (
      output freq_we, freq_ch, freq_d, phase_clr, ch_en, dp_o,
      input  dp_phase, dp_valid, o, o_ch, o_valid
   );

   modport slave (
      input  freq_we, freq_ch, freq_d, phase_clr, ch_en, dp_o,
      output dp_phase, dp_valid, o, o_ch, o_valid
   );
endinterface

// File: rtl/sincos_nco_sched.sv
// Round-robin NCO scheduler sharing one sincos interpolator across NCH channels.
// Define SINCOS_NCO_DITHER_EN to add LFSR phase dither below the interpolator's 14 phase bits.
module sincos_nco_sched #(
   parameter int NCH    = 4,
   parameter int PW     = 32,
   parameter int NBO    = 23,
   parameter int DP_LAT = 5
) (
   input logic               c,
   input logic               r,
   sincos_nco_sched_if.slave bus
);
   localparam int CW = $clog2(NCH);

   logic [CW-1:0]         slot_q, slot_d;
   logic [PW-1:0]         acc_q [NCH];
   logic [PW-1:0]         acc_d [NCH];
   logic [PW-1:0]         freq_word_q [NCH];
   logic [PW-1:0]         freq_word_d [NCH];
   logic [NCH-1:0]        clr_pend_q, clr_pend_d;
   logic [PW-1:0]         dp_phase_q, dp_phase_d;
   logic                  dp_valid_q, dp_valid_d;
   logic [CW-1:0]         dp_ch_q, dp_ch_d;
   logic [DP_LAT-1:0]     tag_v_q, tag_v_d;
   logic [CW-1:0]         tag_ch_q [DP_LAT];
   logic [CW-1:0]         tag_ch_d [DP_LAT];
   logic signed [NBO-1:0] o_q, o_d;
   logic [CW-1:0]         o_ch_q, o_ch_d;
   logic                  o_valid_q, o_valid_d;

   logic                  issue;
   logic                  clr_hit;
   logic [PW-1:0]         base_phase;

`ifdef SINCOS_NCO_DITHER_EN
   localparam int DW = (PW - 14 > 16) ? 16 : PW - 14;
   logic [15:0] lfsr_q, lfsr_d;
   logic [PW-1:0] dither;

   always_comb begin
      lfsr_d = lfsr_q;
      if (issue) begin
         lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      end
      dither = {{(PW-DW){1'b0}}, lfsr_q[DW-1:0]};
   end

   always_ff @(posedge c) begin
      if (r) lfsr_q <= 16'hACE1;
      else   lfsr_q <= lfsr_d;
   end
`endif

   always_comb begin
      slot_d      = slot_q + CW'(1);
      acc_d       = acc_q;
      freq_word_d = freq_word_q;
      clr_pend_d  = clr_pend_q | bus.phase_clr;
      dp_phase_d  = dp_phase_q;
      dp_valid_d  = 1'b0;
      dp_ch_d     = dp_ch_q;
      issue       = bus.ch_en[slot_q];
      clr_hit     = clr_pend_q[slot_q];
      base_phase  = clr_hit ? '0 : acc_q[slot_q];

      // The issuing addition below reads freq_word_q, so a same-clock write lands next visit.
      if (bus.freq_we) freq_word_d[bus.freq_ch] = bus.freq_d;

      if (issue) begin
         dp_valid_d = 1'b1;
         dp_ch_d    = slot_q;
`ifdef SINCOS_NCO_DITHER_EN
         dp_phase_d = base_phase + dither;
`else
         dp_phase_d = base_phase;
`endif
         if (clr_hit) begin
            acc_d[slot_q]      = freq_word_q[slot_q];
            clr_pend_d[slot_q] = bus.phase_clr[slot_q];
         end else begin
            acc_d[slot_q] = acc_q[slot_q] + freq_word_q[slot_q];
         end
      end
   end

   always_comb begin
      tag_v_d     = '0;
      tag_v_d[0]  = dp_valid_q;
      tag_ch_d[0] = dp_ch_q;
      for (int i = 1; i < DP_LAT; i++) begin
         tag_v_d[i]  = tag_v_q[i-1];
         tag_ch_d[i] = tag_ch_q[i-1];
      end
      o_valid_d = tag_v_q[DP_LAT-1];
      o_d       = o_q;
      o_ch_d    = o_ch_q;
      if (tag_v_q[DP_LAT-1]) begin
         o_d    = bus.dp_o;
         o_ch_d = tag_ch_q[DP_LAT-1];
      end
   end

   always_ff @(posedge c) begin
      if (r) begin
         slot_q      <= '0;
         acc_q       <= '{default: '0};
         freq_word_q <= '{default: '0};
         clr_pend_q  <= '0;
         dp_phase_q  <= '0;
         dp_valid_q  <= 1'b0;
         dp_ch_q     <= '0;
         tag_v_q     <= '0;
         tag_ch_q    <= '{default: '0};
         o_q         <= '0;
         o_ch_q      <= '0;
         o_valid_q   <= 1'b0;
      end else begin
         slot_q      <= slot_d;
         acc_q       <= acc_d;
         freq_word_q <= freq_word_d;
         clr_pend_q  <= clr_pend_d;
         dp_phase_q  <= dp_phase_d;
         dp_valid_q  <= dp_valid_d;
         dp_ch_q     <= dp_ch_d;
         tag_v_q     <= tag_v_d;
         tag_ch_q    <= tag_ch_d;
         o_q         <= o_d;
         o_ch_q      <= o_ch_d;
         o_valid_q   <= o_valid_d;
      end
   end

   assign bus.dp_phase = dp_phase_q;
   assign bus.dp_valid = dp_valid_q;
   assign bus.o        = o_q;
   assign bus.o_ch     = o_ch_q;
   assign bus.o_valid  = o_valid_q;
endmodule
